// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: drives the load, shift and clear strobes of an external shift register for one transfer at a time.
// Optional feature macro SHIFT_SEQ_DIV_EN adds the div port and a WAIT state that inserts idle cycles between shifts.
module shift_reg_sequencer #(
    parameter int Length    = 8,
    parameter int Cnt_Width = 8,
    parameter int Div_Width = 8
) (
    input  logic                 clk,
    input  logic                 sres,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 msb_first,
    input  logic [Cnt_Width-1:0] num_bits,
`ifdef SHIFT_SEQ_DIV_EN
    input  logic [Div_Width-1:0] div,
`endif
    output logic                 sr_ld_en,
    output logic                 sr_shift_en,
    output logic                 sr_msb_out_first,
    output logic                 sr_clr,
    output logic                 busy,
    output logic                 done,
    output logic [Cnt_Width-1:0] bit_cnt
);

    localparam logic [Cnt_Width-1:0] LEN = Cnt_Width'(Length);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, SHIFT, DONE} state_t;

    state_t               state_q, state_d;
    logic                 dir_q, dir_d;
    logic [Cnt_Width-1:0] n_q, n_d, cnt_q, cnt_d;
    logic [Cnt_Width-1:0] cnt_inc, n_clamp;
    logic                 ld_q, ld_d, shift_q, shift_d, clr_q, clr_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic                 go, gap, wait_end;

    assign go      = (state_q == IDLE) && start && !abort;
    assign cnt_inc = cnt_q + 1'b1;
    assign n_clamp = (num_bits == '0 || num_bits > LEN) ? LEN : num_bits;

`ifdef SHIFT_SEQ_DIV_EN
    logic [Div_Width-1:0] div_q, div_d, wait_q, wait_d;

    assign gap      = div_q != '0;
    assign wait_end = wait_q == Div_Width'(1);

    // capture div at start; the gap counter reloads outside WAIT and counts down inside it
    always_comb begin
        div_d  = go ? div : div_q;
        wait_d = (state_q == WAIT) ? wait_q - 1'b1 : div_q;
    end

    // divider registers
    always_ff @(posedge clk or posedge sres) begin
        if (sres) begin
            div_q  <= '0;
            wait_q <= '0;
        end else begin
            div_q  <= div_d;
            wait_q <= wait_d;
        end
    end
`else
    localparam int unused_div_width = Div_Width;

    assign gap      = 1'b0;
    assign wait_end = 1'b1;
`endif

    // next state, captured transfer settings and registered strobes
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        n_d     = n_q;
        cnt_d   = (state_q == SHIFT) ? cnt_inc : cnt_q;
        if (go) begin
            state_d = LOAD;
            dir_d   = msb_first;
            n_d     = n_clamp;
            cnt_d   = '0;
        end else if (state_q != IDLE && abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                LOAD:    state_d = gap ? WAIT : SHIFT;
                WAIT:    state_d = wait_end ? SHIFT : WAIT;
                SHIFT:   state_d = (cnt_inc == n_q) ? DONE : (gap ? WAIT : SHIFT);
                default: state_d = IDLE;
            endcase
        end
        ld_d    = state_d == LOAD;
        shift_d = state_d == SHIFT;
        done_d  = state_d == DONE;
        busy_d  = state_d != IDLE;
        clr_d   = (state_q != IDLE) && abort;
    end

    // state and output registers
    always_ff @(posedge clk or posedge sres) begin
        if (sres) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            n_q     <= '0;
            cnt_q   <= '0;
            ld_q    <= 1'b0;
            shift_q <= 1'b0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            ld_q    <= ld_d;
            shift_q <= shift_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sr_ld_en         = ld_q;
    assign sr_shift_en      = shift_q;
    assign sr_msb_out_first = dir_q;
    assign sr_clr           = clr_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign bit_cnt          = cnt_q;

endmodule

// File: doc/shift_reg_sequencer.md
SHIFT_REG_SEQUENCER -- requirements
Module: shift_reg_sequencer

Interface
REQ-001 SHALL have parameter Length, default 8: bit length of the controlled shift register; legal range 2..256.
REQ-002 SHALL have parameter Cnt_Width, default 8: width of num_bits and bit_cnt; must satisfy 2^Cnt_Width > Length.
REQ-003 SHALL have parameter Div_Width, default 8: width of div (used only with SHIFT_SEQ_DIV_EN).
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port sres, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1: request one transfer; sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1: synchronous cancel of a transfer in progress.
REQ-008 SHALL have port msb_first, input, 1: shift direction, captured at start.
REQ-009 SHALL have port num_bits, input, Cnt_Width: bits to shift, captured at start.
REQ-010 SHALL have port div, input, Div_Width: idle cycles between shifts, captured at start (present only with SHIFT_SEQ_DIV_EN).
REQ-011 SHALL have port sr_ld_en, output, 1: parallel-load strobe to the shift register.
REQ-012 SHALL have port sr_shift_en, output, 1: one-cycle shift strobe per bit.
REQ-013 SHALL have port sr_msb_out_first, output, 1: registered direction to the shift register.
REQ-014 SHALL have port sr_clr, output, 1: one-cycle synchronous clear strobe to the shift register.
REQ-015 SHALL have port busy, output, 1: transfer in progress.
REQ-016 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-017 SHALL have port bit_cnt, output, Cnt_Width: bits shifted so far in the current transfer.

Function
REQ-018 SHALL implement states IDLE, LOAD, WAIT, SHIFT, DONE; all outputs registered.
REQ-019 SHALL, in IDLE with start=1 and abort=0, capture msb_first/num_bits/div, clear bit_cnt, and go to LOAD.
REQ-020 SHALL treat num_bits=0 or num_bits>Length as Length.
REQ-021 SHALL assert sr_ld_en for exactly one cycle in LOAD, then go to WAIT if the captured div is nonzero, else SHIFT.
REQ-022 SHALL remain in WAIT for exactly div cycles, then go to SHIFT.
REQ-023 SHALL assert sr_shift_en for one cycle in SHIFT and increment bit_cnt; if bit_cnt reaches N it goes to DONE, else to WAIT/SHIFT per REQ-021.
REQ-024 SHALL place the k-th shift (k=0..N-1) at cycle 2+div+k*(div+1), taking start sampled at cycle 0; done at the cycle after the last shift.
REQ-025 SHALL assert done for one cycle in DONE, then return to IDLE; bit_cnt holds N until the next start.
REQ-026 SHALL assert busy in LOAD, WAIT, SHIFT and DONE; deassert it in IDLE.
REQ-027 SHALL ignore start while busy=1; a start coincident with done is ignored.
REQ-028 SHALL, on abort=1 in any non-IDLE state, pulse sr_clr next cycle, return to IDLE, and suppress done and further strobes.
REQ-029 SHALL give abort priority over start when both are asserted in IDLE; no transfer begins and sr_clr is not pulsed.
REQ-030 SHALL never assert sr_ld_en, sr_shift_en and sr_clr in the same cycle.

Reset
REQ-031 SHALL, while sres=1, asynchronously force IDLE with sr_ld_en, sr_shift_en, sr_clr, busy and done all 0, sr_msb_out_first=0 and bit_cnt=0.
REQ-032 SHALL, on sres asserted mid-transfer, discard the transfer with no done pulse; after release it accepts start on the first clk edge.

Configuration
REQ-033 SHALL, with SHIFT_SEQ_DIV_EN defined, provide the div port and the WAIT state per REQ-021..024.
REQ-034 SHALL, without SHIFT_SEQ_DIV_EN, omit the div port and the WAIT state and behave as div=0 (shift every cycle).

Verification
REQ-035 SHALL cover basic timing: Length=8, num_bits=8, div=0, start at cycle 0 -> ld_en at cycle 1, shift_en at cycles 2..9, done at cycle 10, busy high for cycles 1..10.
REQ-036 SHALL cover divider timing: num_bits=3, div=2 -> shift_en at cycles 4, 7, 10; done at cycle 11; bit_cnt=3 afterwards.
REQ-037 SHALL cover length clamping: num_bits=0, then num_bits=12 with Length=8 -> 8 shift_en pulses each time.
REQ-038 SHALL cover abort: abort after the 3rd shift -> sr_clr pulse next cycle, IDLE, no done, bit_cnt=3.
REQ-039 SHALL cover start during busy and start+abort in IDLE -> both ignored, no ld_en pulse.
REQ-040 SHALL cover async reset: sres pulse between clk edges mid-transfer -> outputs 0 immediately; a new start after release yields a normal REQ-035 sequence.
